// File: rtl/axi_master_ifm_rd_pkg.sv
// Shared definitions for the IFM read master (and the OFM writer that mirrors it).
package axi_master_ifm_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } rd_state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // AXI AxSIZE encoding for a full-width beat: log2 of the bus width in bytes.
  function automatic logic [2:0] axi_size_of(input int unsigned data_w);
    int unsigned bytes;
    logic [2:0]  sz;
    bytes = data_w / 8;
    sz    = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if ((32'd1 << i) == bytes) sz = 3'(i);
    end
    return sz;
  endfunction

  localparam logic [2:0] AXI_SIZE_128B_BUS = axi_size_of(128);

endpackage

// File: rtl/axi_master_ifm_rd_if.sv
// AXI4 read-address and read-data channels between the IFM reader and DDR.
interface axi_master_ifm_rd_if #(
  parameter int unsigned AXI_ADDR_W = 32,
  parameter int unsigned AXI_DATA_W = 128
);
  logic [AXI_ADDR_W-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;

  logic [AXI_DATA_W-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output araddr, arvalid, arlen, arsize, arburst,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  araddr, arvalid, arlen, arsize, arburst,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_master_ifm_rd.sv
// IFM read master: fetches num_bursts fixed-length INCR bursts from DDR and
// streams every beat into consecutive IFM buffer locations.
module axi_master_ifm_rd
  import axi_master_ifm_rd_pkg::*;
#(
  parameter int unsigned AXI_ADDR_W = 32,
  parameter int unsigned AXI_DATA_W = 128,
  parameter int unsigned BUF_ADDR_W = 10,
  parameter int unsigned BURST_LEN  = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_read,
  input  logic [AXI_ADDR_W-1:0] base_addr,
  input  logic [7:0]            num_bursts,
  output logic                  done,
  output logic                  error,
  axi_master_ifm_rd_if.master   axi,
  output logic                  wr_en,
  output logic [BUF_ADDR_W-1:0] wr_addr,
  output logic [AXI_DATA_W-1:0] wr_data
);

  localparam logic [AXI_ADDR_W-1:0] BURST_BYTES = AXI_ADDR_W'(BURST_LEN * (AXI_DATA_W / 8));
  localparam logic [7:0]            ARLEN_VAL   = 8'(BURST_LEN - 1);
  localparam logic [7:0]            LAST_BEAT   = 8'(BURST_LEN - 1);
  localparam logic [2:0]            ARSIZE_VAL  = axi_size_of(AXI_DATA_W);

  rd_state_e             state_q, state_d;
  logic [AXI_ADDR_W-1:0] araddr_q, araddr_d;
  logic                  arvalid_q, arvalid_d;
  logic [7:0]            arlen_q, arlen_d;
  logic [2:0]            arsize_q, arsize_d;
  logic [1:0]            arburst_q, arburst_d;
  logic                  rready_q, rready_d;
  logic                  wr_en_q, wr_en_d;
  logic [BUF_ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [AXI_DATA_W-1:0] wr_data_q, wr_data_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic [7:0]            beat_q, beat_d;
  logic [7:0]            bursts_q, bursts_d;
  logic [BUF_ADDR_W-1:0] ptr_q, ptr_d;

  logic beat_fire;
  logic last_beat;

  assign beat_fire = axi.rvalid && rready_q;
  assign last_beat = (beat_q == LAST_BEAT);

  // Next-state and registered-output computation for the command FSM.
  always_comb begin
    state_d   = state_q;
    araddr_d  = araddr_q;
    arvalid_d = arvalid_q;
    arlen_d   = arlen_q;
    arsize_d  = arsize_q;
    arburst_d = arburst_q;
    rready_d  = rready_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    error_d   = error_q;
    beat_d    = beat_q;
    bursts_d  = bursts_q;
    ptr_d     = ptr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_read) begin
          araddr_d  = base_addr;
          bursts_d  = (num_bursts == 8'd0) ? 8'd1 : num_bursts;
          beat_d    = '0;
          ptr_d     = '0;
          wr_addr_d = '0;
          error_d   = 1'b0;
          arlen_d   = ARLEN_VAL;
          arsize_d  = ARSIZE_VAL;
          arburst_d = AXI_BURST_INCR;
          arvalid_d = 1'b1;
          state_d   = ST_ADDR;
        end
      end

      ST_ADDR: begin
        if (arvalid_q && axi.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_DATA;
        end
      end

      ST_DATA: begin
        if (beat_fire) begin
          // Buffer write trails the R handshake by one cycle; ptr_q holds the
          // slot for the current beat while wr_addr shows the last one written.
          wr_en_d   = 1'b1;
          wr_addr_d = ptr_q;
          wr_data_d = axi.rdata;
          ptr_d     = ptr_q + BUF_ADDR_W'(1);
          if ((axi.rresp != AXI_RESP_OKAY) || (axi.rlast != last_beat)) begin
            error_d = 1'b1;
          end
          // Burst end is decided by our own beat count, never by rlast.
          if (last_beat) begin
            beat_d   = '0;
            rready_d = 1'b0;
            if (bursts_q <= 8'd1) begin
              state_d = ST_DONE;
            end else begin
              bursts_d  = bursts_q - 8'd1;
              araddr_d  = araddr_q + BURST_BYTES;
              arvalid_d = 1'b1;
              state_d   = ST_ADDR;
            end
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end

      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      araddr_q  <= '0;
      arvalid_q <= 1'b0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      arburst_q <= '0;
      rready_q  <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      beat_q    <= '0;
      bursts_q  <= '0;
      ptr_q     <= '0;
    end else begin
      state_q   <= state_d;
      araddr_q  <= araddr_d;
      arvalid_q <= arvalid_d;
      arlen_q   <= arlen_d;
      arsize_q  <= arsize_d;
      arburst_q <= arburst_d;
      rready_q  <= rready_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      error_q   <= error_d;
      beat_q    <= beat_d;
      bursts_q  <= bursts_d;
      ptr_q     <= ptr_d;
    end
  end

  assign axi.araddr  = araddr_q;
  assign axi.arvalid = arvalid_q;
  assign axi.arlen   = arlen_q;
  assign axi.arsize  = arsize_q;
  assign axi.arburst = arburst_q;
  assign axi.rready  = rready_q;
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign done        = done_q;
  assign error       = error_q;

endmodule

// File: tb/tb_axi_master_ifm_rd.sv
// Bench for axi_master_ifm_rd: behavioural AXI read slave, scoreboard of
// expected buffer writes, table of commands plus a reset-mid-burst sequence.
module tb_axi_master_ifm_rd;

  localparam int          BLEN        = 64;
  localparam logic [31:0] BURST_BYTES = 32'd1024;
  localparam int          NV          = 8;

  typedef struct {
    int          nb;
    logic [31:0] base;
    int          ar_delay;
    int          gap;
    int          err_beat;
    int          early_beat;
    bit          poke;
    int          exp_ars;
    int          exp_writes;
    bit          exp_err;
  } vec_t;

  typedef struct packed {
    logic [9:0]   addr;
    logic [127:0] data;
    logic         err;
  } sb_t;

  logic         clk;
  logic         rst_n;
  logic         start_read;
  logic [31:0]  base_addr;
  logic [7:0]   num_bursts;
  logic         done;
  logic         error;
  logic         wr_en;
  logic [9:0]   wr_addr;
  logic [127:0] wr_data;

  axi_master_ifm_rd_if #(.AXI_ADDR_W(32), .AXI_DATA_W(128)) bus ();

  axi_master_ifm_rd #(
    .AXI_ADDR_W(32),
    .AXI_DATA_W(128),
    .BUF_ADDR_W(10),
    .BURST_LEN (64)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_read(start_read),
    .base_addr (base_addr),
    .num_bursts(num_bursts),
    .done      (done),
    .error     (error),
    .axi       (bus),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  sb_t sb[$];
  vec_t vecs[NV];

  int          cfg_ar_delay = 0;
  int          cfg_gap      = 0;
  int          cfg_err_beat = -1;
  int          cfg_early    = -1;
  logic [31:0] cur_base     = '0;
  int          cmd_tag      = 0;
  int          exp_ptr      = 0;
  bit          cum_err      = 0;
  int          ar_seen      = 0;
  int          beats_hs     = 0;
  int          writes_seen  = 0;
  int          done_seen    = 0;

  task automatic check_eq(input string what, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", what, act, exp, $time);
    end
  endtask

  task automatic fail_bound(input string what);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: wait bound expired at %0t", what, $time);
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_araddr",  bus.araddr,  0);
    check_eq("rst_arvalid", bus.arvalid, 0);
    check_eq("rst_arlen",   bus.arlen,   0);
    check_eq("rst_arsize",  bus.arsize,  0);
    check_eq("rst_arburst", bus.arburst, 0);
    check_eq("rst_rready",  bus.rready,  0);
    check_eq("rst_wr_en",   wr_en,       0);
    check_eq("rst_wr_addr", wr_addr,     0);
    check_eq("rst_wr_data", wr_data,     0);
    check_eq("rst_done",    done,        0);
    check_eq("rst_error",   error,       0);
  endtask

  // AXI read slave: handshakes sampled on the falling edge, responses driven
  // just after the rising edge.
  initial begin
    bit          ar_hs, r_hs, chk_rready, ar_wait_prev, cur_bad, last;
    int          ar_wait, beat_in_burst, gap_cnt;
    bit          r_active;
    logic [31:0] prev_araddr;
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = '0; bus.rlast = 1'b0;
    chk_rready = 0; ar_wait_prev = 0; cur_bad = 0; ar_wait = 0;
    beat_in_burst = 0; gap_cnt = 0; r_active = 0; prev_araddr = '0;
    forever begin
      @(negedge clk);
      ar_hs = bus.arvalid && bus.arready;
      r_hs  = bus.rvalid && bus.rready;
      if (rst_n) begin
        if (chk_rready) begin
          check_eq("rready_after_ar", bus.rready, 1);
          chk_rready = 0;
        end
        if (ar_wait_prev) begin
          check_eq("arvalid_held", bus.arvalid, 1);
          check_eq("araddr_held", bus.araddr, prev_araddr);
        end
        ar_wait_prev = bus.arvalid && !bus.arready;
        prev_araddr  = bus.araddr;
        if (ar_hs) begin
          check_eq("araddr",  bus.araddr, cur_base + 32'(ar_seen) * BURST_BYTES);
          check_eq("arlen",   bus.arlen, 63);
          check_eq("arsize",  bus.arsize, 4);
          check_eq("arburst", bus.arburst, 1);
          ar_seen++;
          chk_rready = 1;
        end
        if (r_hs) begin
          cum_err = cum_err | cur_bad;
          sb.push_back('{addr: exp_ptr[9:0], data: bus.rdata, err: cum_err});
          exp_ptr++;
          beats_hs++;
        end
      end
      @(posedge clk);
      #1;
      if (!rst_n) begin
        bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rlast = 1'b0; bus.rresp = '0;
        r_active = 0; gap_cnt = 0; ar_wait = 0; chk_rready = 0; ar_wait_prev = 0;
      end else begin
        if (ar_hs || !bus.arvalid) begin
          ar_wait = 0;
          bus.arready = (cfg_ar_delay == 0);
        end else if (!bus.arready) begin
          ar_wait++;
          if (ar_wait >= cfg_ar_delay) bus.arready = 1'b1;
        end
        if (ar_hs) begin
          r_active = 1; beat_in_burst = 0; gap_cnt = 0;
        end
        if (r_hs) begin
          beat_in_burst++;
          bus.rvalid = 1'b0;
          bus.rlast  = 1'b0;
          gap_cnt    = cfg_gap;
          if (beat_in_burst == BLEN) r_active = 0;
        end
        if (r_active && !bus.rvalid) begin
          if (gap_cnt == 0) begin
            last       = (beat_in_burst == BLEN - 1);
            bus.rvalid = 1'b1;
            bus.rdata  = {32'(cmd_tag), 64'hA5A5_5A5A_0F0F_F0F0, 32'(beats_hs)};
            bus.rresp  = (beats_hs == cfg_err_beat) ? 2'b10 : 2'b00;
            bus.rlast  = last || (beats_hs == cfg_early);
            cur_bad    = (bus.rresp != 2'b00) || (bus.rlast != last);
          end else begin
            gap_cnt--;
          end
        end
      end
    end
  end

  // Buffer-write monitor: pops the scoreboard on every wr_en.
  initial begin
    bit  prev_wr;
    sb_t e;
    prev_wr = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_wr = 0;
      end else begin
        if (wr_en) begin
          writes_seen++;
          if (sb.size() == 0) begin
            fail_bound("wr_unexpected");
          end else begin
            e = sb.pop_front();
            check_eq("wr_addr", wr_addr, e.addr);
            check_eq("wr_data", wr_data, e.data);
            check_eq("error_at_write", error, e.err);
          end
        end
        if (done) begin
          done_seen++;
          check_eq("done_after_final_wr", prev_wr, 1);
        end
        prev_wr = wr_en;
      end
    end
  end

  task automatic start_cmd(input vec_t v);
    cfg_ar_delay = v.ar_delay; cfg_gap = v.gap; cfg_err_beat = v.err_beat; cfg_early = v.early_beat;
    cur_base = v.base;
    cmd_tag++; exp_ptr = 0; cum_err = 0; ar_seen = 0; beats_hs = 0; writes_seen = 0; done_seen = 0;
    @(posedge clk); #1;
    start_read = 1'b1; base_addr = v.base; num_bursts = 8'(v.nb);
    @(posedge clk); #1;
    start_read = 1'b0; base_addr = $urandom; num_bursts = 8'($urandom);
    @(negedge clk);
    check_eq("arvalid_rise", bus.arvalid, 1);
    check_eq("error_clear", error, 0);
  endtask

  task automatic finish_cmd(input vec_t v);
    int k;
    for (k = 0; k < 20000; k++) begin
      @(negedge clk);
      if (done) break;
    end
    if (k == 20000) begin
      fail_bound("done_timeout");
    end else begin
      @(negedge clk); #1;
      check_eq("done_width",  done, 0);
      check_eq("done_count",  done_seen, 1);
      check_eq("ar_count",    ar_seen, v.exp_ars);
      check_eq("write_count", writes_seen, v.exp_writes);
      check_eq("sb_empty",    sb.size(), 0);
      check_eq("error_final", error, v.exp_err);
      check_eq("rready_idle", bus.rready, 0);
    end
  endtask

  task automatic run_cmd(input vec_t v);
    int k;
    start_cmd(v);
    if (v.poke) begin
      for (k = 0; k < 2000; k++) begin
        @(negedge clk);
        if (beats_hs >= 20) break;
      end
      if (k == 2000) fail_bound("poke_wait");
      @(posedge clk); #1;
      start_read = 1'b1; base_addr = 32'hDEAD_0000; num_bursts = 8'd5;
      @(posedge clk); #1;
      start_read = 1'b0;
    end
    finish_cmd(v);
  endtask

  task automatic reset_mid_data();
    vec_t v;
    int   k;
    v = '{1, 32'h5000_0000, 0, 0, -1, -1, 0, 1, 64, 0};
    start_cmd(v);
    for (k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (beats_hs >= 20) break;
    end
    if (k == 2000) fail_bound("reset_wait");
    #1 rst_n = 1'b0;
    #1 check_reset_outputs();
    repeat (2) @(negedge clk);
    sb.delete();
    #1 rst_n = 1'b1;
    v.base = 32'h5400_0000;
    run_cmd(v);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start_read = 1'b0; base_addr = '0; num_bursts = '0;
    //          nb  base            ard gap errb early poke ars writes err
    vecs[0] = '{1,  32'h1000_0000,  0,  0,  -1,  -1,   0,   1,  64,    0};
    vecs[1] = '{3,  32'h2000_0000,  0,  0,  -1,  -1,   0,   3,  192,   0};
    vecs[2] = '{1,  32'h3000_0400,  5,  2,  -1,  -1,   0,   1,  64,    0};
    vecs[3] = '{1,  32'h0000_0000,  0,  0,  10,  30,   0,   1,  64,    1};
    vecs[4] = '{0,  32'h0000_0C00,  0,  0,  -1,  -1,   0,   1,  64,    0};
    vecs[5] = '{1,  32'h6000_0000,  0,  1,  -1,  -1,   1,   1,  64,    0};
    vecs[6] = '{17, 32'h7000_0000,  0,  0,  -1,  -1,   0,   17, 1088,  0};
    vecs[7] = '{2,  32'h8000_0800,  3,  1,  -1,  70,   0,   2,  128,   1};
    repeat (3) @(negedge clk);
    check_reset_outputs();
    #1 rst_n = 1'b1;
    for (int i = 0; i < NV; i++) run_cmd(vecs[i]);
    reset_mid_data();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
